// File: rtl/timing_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : timing_sequencer_if
// Brief    : Control/status bundle between the control unit and the sequencer
// Revision : 1.0
// ============================================================================
interface timing_sequencer_if #(
    parameter int N_STEPS = 12,
    parameter int IDX_W   = 4,
    parameter int CNT_W   = 16
);
    logic               T_Reset;
    logic               Stall;
    logic               Load;
    logic [IDX_W-1:0]   LoadStep;
    logic [N_STEPS-1:0] T;
    logic [IDX_W-1:0]   Step;
    logic               Wrapped;
    logic               Saturated;
    logic               LoadErr;
    logic [CNT_W-1:0]   InstrCount;

    modport master (
        output T_Reset, Stall, Load, LoadStep,
        input  T, Step, Wrapped, Saturated, LoadErr, InstrCount
    );

    modport slave (
        input  T_Reset, Stall, Load, LoadStep,
        output T, Step, Wrapped, Saturated, LoadErr, InstrCount
    );
endinterface
`default_nettype wire

// File: rtl/timing_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : timing_sequencer
// Brief    : One-hot CPU timing-step generator with stall, load, wrap/saturate
// Revision : 1.0
// ============================================================================
module timing_sequencer #(
    parameter int N_STEPS   = 12,
    parameter int IDX_W     = 4,
    parameter int WRAP_MODE = 1,
    parameter int CNT_W     = 16
) (
    input  wire                  Clock,
    input  wire                  Reset,
    timing_sequencer_if.slave    bus
);
    localparam logic [IDX_W-1:0]   c_last_step = IDX_W'(N_STEPS - 1);
    localparam logic [IDX_W:0]     c_n_steps   = (IDX_W + 1)'(N_STEPS);
    localparam logic [N_STEPS-1:0] c_t_one     = N_STEPS'(1);

    logic [IDX_W-1:0] r_step;
    logic             r_saturated;
    logic             r_wrapped;
    logic             r_load_err;
    logic [CNT_W-1:0] r_count;

    logic [IDX_W-1:0] w_step_nxt;
    logic             w_saturated_nxt;
    logic             w_wrapped_nxt;
    logic             w_load_err_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_load_ok;

    assign w_load_ok = ({1'b0, bus.LoadStep} < c_n_steps);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_step      <= '0;
            r_saturated <= 1'b0;
            r_wrapped   <= 1'b0;
            r_load_err  <= 1'b0;
            r_count     <= '0;
        end else begin
            r_step      <= w_step_nxt;
            r_saturated <= w_saturated_nxt;
            r_wrapped   <= w_wrapped_nxt;
            r_load_err  <= w_load_err_nxt;
            r_count     <= w_count_nxt;
        end
    end

    // Priority: T_Reset > Load > Stall > advance (Reset handled in the register).
    always_comb begin
        w_step_nxt      = r_step;
        w_saturated_nxt = r_saturated;
        w_wrapped_nxt   = 1'b0;
        w_load_err_nxt  = 1'b0;
        w_count_nxt     = r_count;

        if (bus.T_Reset) begin
            w_step_nxt      = '0;
            w_saturated_nxt = 1'b0;
            w_count_nxt     = r_count + CNT_W'(1);
        end else if (bus.Load) begin
            if (w_load_ok) begin
                w_step_nxt      = bus.LoadStep;
                w_saturated_nxt = 1'b0;
            end else begin
                w_load_err_nxt  = 1'b1;
            end
        end else if (!bus.Stall) begin
            if (r_step > c_last_step) begin
                // Unreachable code point: fall back to T0 without side effects.
                w_step_nxt = '0;
            end else if (r_step == c_last_step) begin
                if (WRAP_MODE != 0) begin
                    w_step_nxt    = '0;
                    w_wrapped_nxt = 1'b1;
                    w_count_nxt   = r_count + CNT_W'(1);
                end else begin
                    w_saturated_nxt = 1'b1;
                end
            end else begin
                w_step_nxt = r_step + IDX_W'(1);
            end
        end
    end

    assign bus.T          = c_t_one << r_step;
    assign bus.Step       = r_step;
    assign bus.Wrapped    = r_wrapped;
    assign bus.Saturated  = r_saturated;
    assign bus.LoadErr    = r_load_err;
    assign bus.InstrCount = r_count;
endmodule
`default_nettype wire

// File: tb/tb_timing_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_timing_sequencer
// Brief    : Scoreboard bench: wrapping 12-step unit and saturating 6-step unit
// Revision : 1.0
// ============================================================================
module tb_timing_sequencer;
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    always #5 clk = ~clk;

    timing_sequencer_if #(.N_STEPS(12), .IDX_W(4), .CNT_W(4)) bus_a ();
    timing_sequencer_if #(.N_STEPS(6),  .IDX_W(3), .CNT_W(4)) bus_b ();

    timing_sequencer #(.N_STEPS(12), .IDX_W(4), .WRAP_MODE(1), .CNT_W(4)) dut_a (
        .Clock (clk),
        .Reset (rst_a),
        .bus   (bus_a.slave)
    );

    timing_sequencer #(.N_STEPS(6), .IDX_W(3), .WRAP_MODE(0), .CNT_W(4)) dut_b (
        .Clock (clk),
        .Reset (rst_b),
        .bus   (bus_b.slave)
    );

    typedef struct {
        int          sel;
        int          id;
        logic [4:0]  step;
        logic [11:0] t;
        logic        wr;
        logic        sat;
        logic        lerr;
        logic [3:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   vec_id   = 0;

    // Drive one cycle of stimulus to the selected unit; the other is held in reset.
    task automatic drv(input int sel, input logic rst, input logic trs, input logic stl,
                       input logic ld, input logic [3:0] ls, input int es,
                       input logic ewr, input logic esat, input logic elerr,
                       input logic [3:0] ecnt);
        exp_t        e;
        logic [11:0] one;
        @(negedge clk);
        if (sel == 0) begin
            rst_a = rst; bus_a.T_Reset = trs; bus_a.Stall = stl;
            bus_a.Load = ld; bus_a.LoadStep = ls;
            rst_b = 1'b1;
        end else begin
            rst_b = rst; bus_b.T_Reset = trs; bus_b.Stall = stl;
            bus_b.Load = ld; bus_b.LoadStep = ls[2:0];
            rst_a = 1'b1;
        end
        one    = 12'd1;
        e.sel  = sel;
        e.id   = vec_id;
        e.step = 5'(es);
        e.t    = one << es;
        e.wr   = ewr;
        e.sat  = esat;
        e.lerr = elerr;
        e.cnt  = ecnt;
        exp_q.push_back(e);
        vec_id++;
    endtask

    // Monitor: every edge the DUT presents a fresh output set; compare against queue head.
    initial begin
        exp_t        e;
        logic [4:0]  a_step;
        logic [11:0] a_t;
        logic        a_wr, a_sat, a_lerr;
        logic [3:0]  a_cnt;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.sel == 0) begin
                    a_step = {1'b0, bus_a.Step}; a_t = bus_a.T;
                    a_wr = bus_a.Wrapped; a_sat = bus_a.Saturated;
                    a_lerr = bus_a.LoadErr; a_cnt = bus_a.InstrCount;
                end else begin
                    a_step = {2'b0, bus_b.Step}; a_t = {6'b0, bus_b.T};
                    a_wr = bus_b.Wrapped; a_sat = bus_b.Saturated;
                    a_lerr = bus_b.LoadErr; a_cnt = bus_b.InstrCount;
                end
                n_checks++;
                if (a_step === e.step && a_t === e.t && a_wr === e.wr &&
                    a_sat === e.sat && a_lerr === e.lerr && a_cnt === e.cnt) begin
                    n_pass++;
                end else begin
                    $display("FAIL vec%0d dut%0d: got step=%0d T=%h wr=%b sat=%b lerr=%b cnt=%0d, want step=%0d T=%h wr=%b sat=%b lerr=%b cnt=%0d",
                             e.id, e.sel, a_step, a_t, a_wr, a_sat, a_lerr, a_cnt,
                             e.step, e.t, e.wr, e.sat, e.lerr, e.cnt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bus_a.T_Reset = 1'b0; bus_a.Stall = 1'b0; bus_a.Load = 1'b0; bus_a.LoadStep = '0;
        bus_b.T_Reset = 1'b0; bus_b.Stall = 1'b0; bus_b.Load = 1'b0; bus_b.LoadStep = '0;

        // Unit A: free-run through all 12 steps and wrap.
        drv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 11; k++) drv(0, 0, 0, 0, 0, 0, k, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        drv(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);

        // T_Reset beats Load and Stall.
        drv(0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 1);
        drv(0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 1);
        drv(0, 0, 1, 1, 1, 7, 0, 0, 0, 0, 2);

        // Stall holds step 2 for three edges, then resumes.
        drv(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2);
        drv(0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 2);
        for (int k = 0; k < 3; k++) drv(0, 0, 0, 1, 0, 0, 2, 0, 0, 0, 2);
        drv(0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 2);

        // Legal and illegal loads, including LoadStep == N_STEPS and Load over Stall.
        drv(0, 0, 0, 0, 1, 9, 9, 0, 0, 0, 2);
        drv(0, 0, 0, 0, 1, 13, 9, 0, 0, 1, 2);
        drv(0, 0, 0, 0, 0, 0, 10, 0, 0, 0, 2);
        drv(0, 0, 0, 0, 1, 12, 10, 0, 0, 1, 2);
        drv(0, 0, 0, 1, 1, 11, 11, 0, 0, 0, 2);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3);

        // 16 instructions: counter passes 15 -> 0.
        for (int i = 1; i <= 16; i++) begin
            drv(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'(2 + i));
            drv(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'(3 + i));
        end

        // Reset mid-instruction with Stall and with T_Reset: no count increment.
        drv(0, 0, 0, 0, 1, 7, 7, 0, 0, 0, 3);
        drv(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        drv(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Unit B: saturating 6-step sequencer.
        drv(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drv(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) drv(1, 0, 0, 0, 0, 0, k, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 5, 0, 1, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 5, 0, 1, 0, 0);
        drv(1, 0, 0, 1, 0, 0, 5, 0, 1, 0, 0);
        drv(1, 0, 0, 0, 1, 7, 5, 0, 1, 1, 0);
        drv(1, 0, 0, 0, 1, 2, 2, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 1, 6, 2, 0, 0, 1, 0);
        drv(1, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 5, 0, 1, 0, 0);
        drv(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        drv(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expected entries left unchecked, want 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/timing_sequencer.md
Name: timing_sequencer

Overview:
Parametrised successor to the fixed 12-step sequence counter that drives the CPU control unit's one-hot timing signals T.
- Generates one-hot step outputs T[N_STEPS-1:0] plus a binary step index.
- Adds stall, direct step load, selectable wrap or saturate at the last step, and a retired-instruction counter.
- Sits between the system clock/reset and the control unit; the control unit drives T_Reset at the end of every instruction.

Parameters:
N_STEPS, 12, number of timing steps (2..32)
IDX_W, 4, width of Step/LoadStep; must satisfy 2**IDX_W >= N_STEPS
WRAP_MODE, 1, 1 = advance from last step wraps to T0; 0 = hold at last step and raise Saturated
CNT_W, 16, width of InstrCount

Ports:
Clock  in  1  system clock, all state updates on rising edge
Reset  in  1  synchronous active-high reset
T_Reset  in  1  end-of-instruction; return to T0 next edge
Stall  in  1  hold current step (wait state)
Load  in  1  jump to LoadStep next edge
LoadStep  in  IDX_W  target step index for Load
T  out  N_STEPS  one-hot timing signals, T[k] high during step k
Step  out  IDX_W  binary index of current step
Wrapped  out  1  one-cycle pulse, last step advanced to T0 (WRAP_MODE=1)
Saturated  out  1  level, sequencer parked at last step (WRAP_MODE=0)
LoadErr  out  1  one-cycle pulse, Load with LoadStep >= N_STEPS
InstrCount  out  CNT_W  count of completed instructions

Behaviour:
- One clock, Clock; reset is synchronous and active-high, port Reset. No asynchronous paths.
- Reset values, sampled on the edge with Reset=1: Step=0, T=1 (only T[0] high), Wrapped=0, Saturated=0, LoadErr=0, InstrCount=0.
- T is always exactly one-hot and always equals 1<<Step. It is decoded from registered Step with no extra latency.
- Per-edge priority, highest first: Reset > T_Reset > Load > Stall > advance.
- T_Reset: Step<=0, Saturated<=0, InstrCount<=InstrCount+1. Load and Stall are ignored in the same cycle.
- Load, LoadStep < N_STEPS: Step<=LoadStep, Saturated<=0. InstrCount unchanged.
- Load, LoadStep >= N_STEPS: Step holds, LoadErr pulses high for 1 cycle.
- Stall (no T_Reset/Load): Step, Saturated and InstrCount hold.
- Advance, Step < N_STEPS-1: Step<=Step+1.
- Advance at Step = N_STEPS-1, WRAP_MODE=1: Step<=0, Wrapped pulses 1 cycle, InstrCount<=InstrCount+1. A runaway instruction counts as completed.
- Advance at Step = N_STEPS-1, WRAP_MODE=0: Step holds, Saturated<=1 and stays high until T_Reset, Load or Reset.
- Wrapped and LoadErr are registered pulses: high in the cycle after the causing edge, cleared on the following edge unless the cause repeats.
- InstrCount wraps modulo 2**CNT_W silently.
- Reset mid-instruction, at any step with any inputs, lands at T0 on that edge. InstrCount is not incremented by Reset.
- Unused Step codes (>= N_STEPS) are unreachable. Any illegal Step value must recover to 0 on the next non-stalled edge.

Test Plan:
1. Reset=1 for 2 cycles then released, no other inputs, N_STEPS=12 → T=0x001 after reset; T=0x002, 0x004 … 0x800 on successive edges. Then T=0x001 with Wrapped=1 for one cycle, InstrCount=1.
2. Advance to Step=3, assert T_Reset and Load(LoadStep=7) together → next cycle Step=0, T=0x001, InstrCount incremented by 1.
3. At Step=2, Stall=1 for 3 cycles → Step stays 2 (T=0x004) for 3 cycles. It resumes at Step=3 on the edge after Stall drops.
4. Load LoadStep=9 → Step=9, T=0x200. Then Load LoadStep=13 → Step stays at its current value and LoadErr=1 for exactly one cycle.
5. WRAP_MODE=0, N_STEPS=6, free-run → Step reaches 5 and holds, Saturated=1, InstrCount=0. Then T_Reset → Step=0, Saturated=0, InstrCount=1.
6. CNT_W=4: run 16 T_Reset-terminated instructions → InstrCount goes 15→0. Asserting Reset at Step=7 with Stall=1 → Step=0 next edge, InstrCount=0.
